param_bus_bridge: RTL and testbench

//  Avalon-MM slave bridge between the host CPU and the FM-synth parameter register file.

---
 rtl/param_bus_bridge_pkg.sv | 54 +++++
 rtl/param_bus_bridge_if.sv | 32 +++
 rtl/param_bus_bridge_strobe.sv | 53 +++++
 rtl/param_bus_bridge.sv | 161 ++++++++++++++++
 tb/tb_param_bus_bridge.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/param_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// fm_param_pkg
// Shared constants, FSM state encodings and helper functions for the
// FM-synth parameter bus bridge.
//   NUMOSCS / NUMPARAMS : register file geometry (rows x columns)
//   OSC_W / PAR_W       : index field widths inside the flat word address
//   ADDR_W              : word address width, {osc_idx, par_idx}
//   byte_merge()        : per-byte-lane select between old and new words
//   addr_in_range()     : true when both index fields address a real entry
// -----------------------------------------------------------------------------
package fm_param_pkg;

   localparam int NUMOSCS   = 12;
   localparam int NUMPARAMS = 24;
   localparam int OSC_W     = $clog2(NUMOSCS);
   localparam int PAR_W     = $clog2(NUMPARAMS);
   localparam int ADDR_W    = OSC_W + PAR_W;

   // Plain constants so the state register can stay a simple logic vector.
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_ISSUE = 3'd1;
   localparam logic [2:0] S_RD_WAIT  = 3'd2;
   localparam logic [2:0] S_MERGE    = 3'd3;
   localparam logic [2:0] S_WR       = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   typedef enum logic [2:0] {
      IDLE     = S_IDLE,
      RD_ISSUE = S_RD_ISSUE,
      RD_WAIT  = S_RD_WAIT,
      MERGE    = S_MERGE,
      WR       = S_WR,
      DONE     = S_DONE
   } state_t;

   // Byte lanes with be set come from new_word, the rest keep old_word.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
      end
      return r;
   endfunction

   // The index fields are power-of-two wide, so some codes name no entry.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return (int'(addr[ADDR_W-1:PAR_W]) < NUMOSCS) &&
             (int'(addr[PAR_W-1:0]) < NUMPARAMS);
   endfunction

endpackage

// File: rtl/param_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// param_bus_bridge_if
// Avalon-MM slave-side bundle between the host CPU and the parameter bridge.
//   address     : {osc_idx, par_idx} word address
//   read/write  : request strobes, held until waitrequest drops
//   writedata   : 32-bit write data, byteenable selects the lanes applied
//   readdata    : read result, valid in the waitrequest-low cycle of a read
//   waitrequest : high = stall, low for exactly one cycle on completion
// Modports: slave (the bridge), master (the host / testbench).
// -----------------------------------------------------------------------------
interface param_bus_bridge_if;
   import fm_param_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;
   logic              waitrequest;

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest
   );

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest
   );

endinterface

// File: rtl/param_bus_bridge_strobe.sv
// -----------------------------------------------------------------------------
// param_strobe_gen
// Registered one-hot read/write strobe generator for the parameter regfile.
//   clk, reset        : clock, asynchronous active-high reset
//   osc_idx, par_idx  : entry to strobe on the next cycle
//   rd_go, wr_go      : request a one-cycle rden / wren pulse (mutually exclusive)
//   rf_rden, rf_wren  : per-entry strobes, registered, cleared at once by reset
// -----------------------------------------------------------------------------
module param_strobe_gen
   import fm_param_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [OSC_W-1:0] osc_idx,
   input  logic [PAR_W-1:0] par_idx,
   input  logic             rd_go,
   input  logic             wr_go,
   output logic             rf_rden [NUMOSCS][NUMPARAMS],
   output logic             rf_wren [NUMOSCS][NUMPARAMS]
);

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUMOSCS; gi = gi + 1) begin : g_osc
         for (gj = 0; gj < NUMPARAMS; gj = gj + 1) begin : g_par
            logic hit;
            logic rden_d, wren_d;
            logic rden_q, wren_q;

            always_comb begin
               hit    = (osc_idx == OSC_W'(gi)) && (par_idx == PAR_W'(gj));
               // Write wins if both were ever requested, keeping rden/wren exclusive.
               rden_d = rd_go && !wr_go && hit;
               wren_d = wr_go && hit;
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  rden_q <= 1'b0;
                  wren_q <= 1'b0;
               end else begin
                  rden_q <= rden_d;
                  wren_q <= wren_d;
               end
            end

            assign rf_rden[gi][gj] = rden_q;
            assign rf_wren[gi][gj] = wren_q;
         end
      end
   endgenerate

endmodule

// File: rtl/param_bus_bridge.sv
// -----------------------------------------------------------------------------
// param_bus_bridge
// Avalon-MM slave bridge from the host CPU to the FM-synth parameter regfile.
// Decodes the word address into (oscillator, parameter), issues one-hot
// rden/wren strobes, returns registered read data and performs
// read-modify-write for partial byte-enable writes.
//   clk, reset  : clock, asynchronous active-high reset
//   avs         : Avalon-MM slave bundle (param_bus_bridge_if.slave)
//   rf_rden     : one-hot read strobe, regfile data valid one cycle later
//   rf_wren     : one-hot write strobe
//   rf_wdata    : write data broadcast to every regfile entry
//   rf_rdata    : regfile read outputs, one word per entry
//   err_count   : saturating count of erroneous requests
// Latency from request cycle: full write 2, read 3, partial write 4,
// error / empty write 1.
// -----------------------------------------------------------------------------
module param_bus_bridge
   import fm_param_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   param_bus_bridge_if.slave   avs,
   output logic                rf_rden  [NUMOSCS][NUMPARAMS],
   output logic                rf_wren  [NUMOSCS][NUMPARAMS],
   output logic [31:0]         rf_wdata,
   input  logic [31:0]         rf_rdata [NUMOSCS][NUMPARAMS],
   output logic [15:0]         err_count
);

   logic [2:0]       state_q, state_d;
   logic [OSC_W-1:0] osc_q, osc_d;
   logic [PAR_W-1:0] par_q, par_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic             is_rd_q, is_rd_d;
   logic             waitreq_q, waitreq_d;
   logic [31:0]      readdata_q, readdata_d;   // also serves as the read hold register
   logic [31:0]      rf_wdata_q, rf_wdata_d;
   logic [15:0]      err_q, err_d;
   logic             rd_go, wr_go;
   logic [31:0]      rdata_sel;

   // Latched indices are always in range whenever this mux is consumed (RD_WAIT).
   assign rdata_sel = rf_rdata[osc_q][par_q];

   always_comb begin
      state_d    = state_q;
      osc_d      = osc_q;
      par_d      = par_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      is_rd_d    = is_rd_q;
      waitreq_d  = 1'b1;
      readdata_d = readdata_q;
      rf_wdata_d = rf_wdata_q;
      err_d      = err_q;
      rd_go      = 1'b0;
      wr_go      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Capture the request; later changes on the bus are ignored.
            osc_d   = avs.address[ADDR_W-1:PAR_W];
            par_d   = avs.address[PAR_W-1:0];
            wdata_d = avs.writedata;
            be_d    = avs.byteenable;
            is_rd_d = avs.read;
            if (avs.read || avs.write) begin
               if ((avs.read && avs.write) || !addr_in_range(avs.address)) begin
                  state_d    = S_DONE;
                  waitreq_d  = 1'b0;
                  readdata_d = '0;
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               end else if (avs.write && (avs.byteenable == 4'h0)) begin
                  state_d    = S_DONE;
                  waitreq_d  = 1'b0;
                  readdata_d = '0;
               end else if (avs.write && (avs.byteenable == 4'hF)) begin
                  state_d    = S_WR;
                  wr_go      = 1'b1;
                  rf_wdata_d = avs.writedata;
               end else begin
                  // Reads and partial writes both start with a regfile read.
                  state_d = S_RD_ISSUE;
                  rd_go   = 1'b1;
               end
            end
         end

         S_RD_ISSUE: state_d = S_RD_WAIT;

         S_RD_WAIT: begin
            if (is_rd_q) begin
               state_d    = S_DONE;
               waitreq_d  = 1'b0;
               readdata_d = rdata_sel;
            end else begin
               // Merge is computed here so the wren and merged data land together.
               state_d    = S_MERGE;
               wr_go      = 1'b1;
               rf_wdata_d = byte_merge(rdata_sel, wdata_q, be_q);
            end
         end

         S_MERGE, S_WR: begin
            state_d    = S_DONE;
            waitreq_d  = 1'b0;
            readdata_d = '0;
         end

         S_DONE:  state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         osc_q      <= '0;
         par_q      <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         is_rd_q    <= 1'b0;
         waitreq_q  <= 1'b1;
         readdata_q <= '0;
         rf_wdata_q <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         osc_q      <= osc_d;
         par_q      <= par_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         is_rd_q    <= is_rd_d;
         waitreq_q  <= waitreq_d;
         readdata_q <= readdata_d;
         rf_wdata_q <= rf_wdata_d;
         err_q      <= err_d;
      end
   end

   // Strobes target the entry being captured this cycle (osc_d/par_d), so
   // they appear in the cycle right after the decision.
   param_strobe_gen u_strobe (
      .clk     (clk),
      .reset   (reset),
      .osc_idx (osc_d),
      .par_idx (par_d),
      .rd_go   (rd_go),
      .wr_go   (wr_go),
      .rf_rden (rf_rden),
      .rf_wren (rf_wren)
   );

   assign avs.readdata    = readdata_q;
   assign avs.waitrequest = waitreq_q;
   assign rf_wdata        = rf_wdata_q;
   assign err_count       = err_q;

endmodule

// File: tb/tb_param_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_param_bus_bridge
// Directed bench for param_bus_bridge with a behavioural regfile behind it.
// The regfile model only presents valid data one cycle after rden; other
// cycles show a poison pattern.
// -----------------------------------------------------------------------------
module tb_param_bus_bridge;
   import fm_param_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rf_rden  [NUMOSCS][NUMPARAMS];
   logic        rf_wren  [NUMOSCS][NUMPARAMS];
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata [NUMOSCS][NUMPARAMS];
   logic [15:0] err_count;
   logic [31:0] mem      [NUMOSCS][NUMPARAMS];

   param_bus_bridge_if bus ();

   param_bus_bridge dut (
      .clk       (clk),
      .reset     (reset),
      .avs       (bus),
      .rf_rden   (rf_rden),
      .rf_wren   (rf_wren),
      .rf_wdata  (rf_wdata),
      .rf_rdata  (rf_rdata),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Regfile model
   always @(posedge clk) begin
      for (int o = 0; o < NUMOSCS; o++) begin
         for (int p = 0; p < NUMPARAMS; p++) begin
            if (rf_wren[o][p]) mem[o][p] <= rf_wdata;
            rf_rdata[o][p] <= rf_rden[o][p] ? mem[o][p] : 32'hBAD0_BAD0;
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   int          t_done, t_rd_cyc, t_wr_cyc, t_rd_pos, t_wr_pos, t_rd_n, t_wr_n, t_multi;
   logic [31:0] t_wval, t_rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tally(output int nr, output int nw, output int pr, output int pw);
      nr = 0; nw = 0; pr = -1; pw = -1;
      for (int o = 0; o < NUMOSCS; o++) begin
         for (int p = 0; p < NUMPARAMS; p++) begin
            if (rf_rden[o][p]) begin nr++; pr = o*NUMPARAMS + p; end
            if (rf_wren[o][p]) begin nw++; pw = o*NUMPARAMS + p; end
         end
      end
   endtask

   function automatic logic [ADDR_W-1:0] mk_addr(input int o, input int p);
      logic [OSC_W-1:0] ob;
      logic [PAR_W-1:0] pb;
      ob = o[OSC_W-1:0];
      pb = p[PAR_W-1:0];
      return {ob, pb};
   endfunction

   // Present one request in cycle 0 and record strobes/completion per cycle.
   task automatic do_txn(input logic rd, input logic wr, input int o, input int p,
                         input logic [31:0] wd, input logic [3:0] be);
      int nr, nw, pr, pw;
      t_done = -1; t_rd_cyc = -1; t_wr_cyc = -1; t_rd_pos = -1; t_wr_pos = -1;
      t_rd_n = 0; t_wr_n = 0; t_multi = 0; t_wval = '0; t_rdata = '0;
      @(negedge clk);
      bus.read = rd; bus.write = wr; bus.address = mk_addr(o, p);
      bus.writedata = wd; bus.byteenable = be;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         tally(nr, nw, pr, pw);
         if (nr + nw > 1) t_multi++;
         if (nr > 0) begin
            t_rd_n += nr;
            if (t_rd_cyc < 0) begin t_rd_cyc = k; t_rd_pos = pr; end
         end
         if (nw > 0) begin
            t_wr_n += nw;
            if (t_wr_cyc < 0) begin t_wr_cyc = k; t_wr_pos = pw; t_wval = rf_wdata; end
         end
         if (!bus.waitrequest) begin
            t_done = k;
            t_rdata = bus.readdata;
            break;
         end
      end
      bus.read = 1'b0; bus.write = 1'b0;
      $display("txn rd=%0b wr=%0b osc=%0d par=%0d wd=%08h be=%h done=%0d rdcyc=%0d wrcyc=%0d wval=%08h rdata=%08h err=%04h",
               rd, wr, o, p, wd, be, t_done, t_rd_cyc, t_wr_cyc, t_wval, t_rdata, err_count);
   endtask

   task automatic chk_txn(input string tag, input int e_done, input int e_rdc, input int e_rdpos,
                          input int e_wrc, input int e_wrpos, input logic [31:0] e_wval,
                          input logic [31:0] e_rdata);
      chk({tag, "_lat"},   t_done,   e_done);
      chk({tag, "_rdcyc"}, t_rd_cyc, e_rdc);
      chk({tag, "_rdpos"}, t_rd_pos, e_rdpos);
      chk({tag, "_rdn"},   t_rd_n,   (e_rdc < 0) ? 0 : 1);
      chk({tag, "_wrcyc"}, t_wr_cyc, e_wrc);
      chk({tag, "_wrpos"}, t_wr_pos, e_wrpos);
      chk({tag, "_wrn"},   t_wr_n,   (e_wrc < 0) ? 0 : 1);
      chk({tag, "_wval"},  t_wval,   e_wval);
      chk({tag, "_rdata"}, t_rdata,  e_rdata);
      chk({tag, "_multi"}, t_multi,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nr, nw, pr, pw;
      bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
      bus.writedata = '0; bus.byteenable = '0;

      // Reset state
      @(negedge clk);
      tally(nr, nw, pr, pw);
      chk("rst_waitreq", 32'(bus.waitrequest), 1);
      chk("rst_readdata", bus.readdata, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_err", 32'(err_count), 0);
      chk("rst_strobes", nr + nw, 0);
      @(negedge clk);
      reset = 1'b0;

      // 1: full write to {3,7}
      do_txn(1'b0, 1'b1, 3, 7, 32'hCAFE_F00D, 4'hF);
      chk_txn("t1", 2, -1, -1, 1, 79, 32'hCAFE_F00D, 0);
      // 2: read it back
      do_txn(1'b1, 1'b0, 3, 7, 32'h0, 4'h0);
      chk_txn("t2", 3, 1, 79, -1, -1, 0, 32'hCAFE_F00D);
      // 3: preset {5,2}, partial write be=0101, read back
      do_txn(1'b0, 1'b1, 5, 2, 32'h1122_3344, 4'hF);
      chk_txn("t3_pre", 2, -1, -1, 1, 122, 32'h1122_3344, 0);
      do_txn(1'b0, 1'b1, 5, 2, 32'hAABB_CCDD, 4'b0101);
      chk_txn("t3_rmw", 4, 1, 122, 3, 122, 32'h11BB_33DD, 0);
      do_txn(1'b1, 1'b0, 5, 2, 32'h0, 4'h0);
      chk_txn("t3_rb", 3, 1, 122, -1, -1, 0, 32'h11BB_33DD);
      // Empty byte-enable write: no access, no error
      do_txn(1'b0, 1'b1, 5, 2, 32'hFFFF_FFFF, 4'h0);
      chk_txn("t3_be0", 1, -1, -1, -1, -1, 0, 0);
      chk("t3_be0_err", 32'(err_count), 0);
      do_txn(1'b1, 1'b0, 5, 2, 32'h0, 4'h0);
      chk_txn("t3_be0_rb", 3, 1, 122, -1, -1, 0, 32'h11BB_33DD);
      // Last in-range entry
      do_txn(1'b0, 1'b1, 11, 23, 32'h5A5A_0001, 4'hF);
      chk_txn("edge_wr", 2, -1, -1, 1, 287, 32'h5A5A_0001, 0);
      do_txn(1'b1, 1'b0, 11, 23, 32'h0, 4'h0);
      chk_txn("edge_rd", 3, 1, 287, -1, -1, 0, 32'h5A5A_0001);

      // 4: out-of-range reads
      do_txn(1'b1, 1'b0, 12, 0, 32'h0, 4'h0);
      chk_txn("t4_osc", 1, -1, -1, -1, -1, 0, 0);
      do_txn(1'b1, 1'b0, 0, 24, 32'h0, 4'h0);
      chk_txn("t4_par", 1, -1, -1, -1, -1, 0, 0);
      chk("t4_err", 32'(err_count), 2);
      do_txn(1'b0, 1'b1, 15, 31, 32'h1234_5678, 4'hF);
      chk_txn("t4_wr", 1, -1, -1, -1, -1, 0, 0);
      chk("t4_wr_err", 32'(err_count), 3);

      // 5: read and write together
      do_txn(1'b1, 1'b1, 1, 1, 32'h0, 4'hF);
      chk_txn("t5_rw", 1, -1, -1, -1, -1, 0, 0);
      chk("t5_err", 32'(err_count), 4);

      // Saturation: preload the counter just below the top
      @(negedge clk);
      force dut.err_q = 16'hFFFD;
      #1 release dut.err_q;
      do_txn(1'b1, 1'b1, 1, 1, 32'h0, 4'hF);
      chk("sat_1", 32'(err_count), 32'h0000_FFFE);
      do_txn(1'b1, 1'b1, 1, 1, 32'h0, 4'hF);
      chk("sat_2", 32'(err_count), 32'h0000_FFFF);
      do_txn(1'b1, 1'b1, 1, 1, 32'h0, 4'hF);
      chk("sat_3", 32'(err_count), 32'h0000_FFFF);
      do_txn(1'b1, 1'b0, 13, 3, 32'h0, 4'h0);
      chk("sat_4", 32'(err_count), 32'h0000_FFFF);

      // Leave non-zero read data on the bus before the reset test
      do_txn(1'b1, 1'b0, 5, 2, 32'h0, 4'h0);
      chk_txn("pre6", 3, 1, 122, -1, -1, 0, 32'h11BB_33DD);

      // 6: reset during RD_WAIT
      @(negedge clk);
      bus.read = 1'b1; bus.address = mk_addr(3, 7);
      @(negedge clk);
      tally(nr, nw, pr, pw);
      chk("t6_rden_c1", nr, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      tally(nr, nw, pr, pw);
      chk("t6_strobes", nr + nw, 0);
      chk("t6_waitreq", 32'(bus.waitrequest), 1);
      chk("t6_readdata", bus.readdata, 0);
      chk("t6_err", 32'(err_count), 0);
      bus.read = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Reset while wren is high drops it at once and the write is lost
      @(negedge clk);
      bus.write = 1'b1; bus.address = mk_addr(3, 7);
      bus.writedata = 32'h1234_5678; bus.byteenable = 4'hF;
      @(negedge clk);
      tally(nr, nw, pr, pw);
      chk("t6w_wren_c1", nw, 1);
      reset = 1'b1;
      #1;
      tally(nr, nw, pr, pw);
      chk("t6w_wren_drop", nw, 0);
      chk("t6w_wdata", rf_wdata, 0);
      bus.write = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      do_txn(1'b1, 1'b0, 3, 7, 32'h0, 4'h0);
      chk_txn("t6_abort_rb", 3, 1, 79, -1, -1, 0, 32'hCAFE_F00D);
      do_txn(1'b0, 1'b1, 4, 4, 32'h1357_9BDF, 4'hF);
      chk_txn("t6_post_wr", 2, -1, -1, 1, 100, 32'h1357_9BDF, 0);
      do_txn(1'b1, 1'b0, 4, 4, 32'h0, 4'h0);
      chk_txn("t6_post_rd", 3, 1, 100, -1, -1, 0, 32'h1357_9BDF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
